// File: rtl/btn_gesture_pkg.sv
// Shared constants, FSM encoding and sizing helper for btn_gesture_decoder.
package btn_gesture_pkg;

  // Event type codes carried on evt_type
  localparam logic [1:0] EVT_CLICK  = 2'd0;
  localparam logic [1:0] EVT_LONG   = 2'd1;
  localparam logic [1:0] EVT_REPEAT = 2'd2;

  // Per-channel gesture FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    GAP     = 2'd2,
    HELD    = 2'd3
  } gst_state_e;

  // Timer width able to reach the largest of the three timeouts
  function automatic int unsigned timer_width(input int unsigned long_cyc,
                                              input int unsigned gap_cyc,
                                              input int unsigned rep_cyc);
    int unsigned m;
    m = long_cyc;
    if (gap_cyc > m) m = gap_cyc;
    if (rep_cyc > m) m = rep_cyc;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/btn_gesture_decoder_if.sv
// Button-in / event-out bundle between the button pads and the gesture decoder.
interface btn_gesture_decoder_if #(
  parameter int unsigned N_CH  = 1,
  parameter int unsigned CNT_W = 3
);
  logic [N_CH-1:0]       btn_raw;
  logic [N_CH-1:0]       btn_level;
  logic [N_CH-1:0]       evt_valid;
  logic [2*N_CH-1:0]     evt_type;
  logic [CNT_W*N_CH-1:0] evt_clicks;

  // Button source / event consumer side
  modport master (
    output btn_raw,
    input  btn_level, evt_valid, evt_type, evt_clicks
  );

  // Decoder side
  modport slave (
    input  btn_raw,
    output btn_level, evt_valid, evt_type, evt_clicks
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-sample debounce for one button channel.
// Both edges see the same latency, so debounced pulse width tracks the raw one.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 2
) (
  input  logic clk,
  input  logic btn_reset,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned DC_W = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [DC_W-1:0] r_cnt;

  // Synchronise, then load the new level after DEB_CYC consecutive differing samples
  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == DC_W'(DEB_CYC - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/btn_gesture_decoder.sv
// Multi-channel button gesture decoder: click count / long press / held-repeat.
// Optional feature macro: GESTURE_REPEAT_EN (periodic REPEAT events while held).
module btn_gesture_decoder
  import btn_gesture_pkg::*;
#(
  parameter int unsigned N_CH       = 1,
  parameter int unsigned DEB_CYC    = 2,
  parameter int unsigned LONG_CYC   = 10,
  parameter int unsigned GAP_CYC    = 15,
  parameter int unsigned REPEAT_CYC = 20,
  parameter int unsigned MAX_CLICKS = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  btn_reset,
  btn_gesture_decoder_if.slave  bus
);

  localparam int unsigned TMR_W = timer_width(LONG_CYC, GAP_CYC, REPEAT_CYC);
  localparam logic [TMR_W-1:0] TMR_MAX = '1;

  logic [N_CH-1:0]       w_level_all;
  logic [N_CH-1:0]       w_valid_all;
  logic [2*N_CH-1:0]     w_type_all;
  logic [CNT_W*N_CH-1:0] w_clicks_all;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic             w_level;
    gst_state_e       r_state;
    gst_state_e       w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [TMR_W-1:0] w_timer_inc;
    logic [CNT_W-1:0] r_clicks;
    logic [CNT_W-1:0] w_clicks_nxt;
    logic [CNT_W-1:0] w_clicks_inc;
    logic             w_max_hit;
    logic             w_long_hit;
    logic             w_gap_hit;
    logic             w_rep_hit;
    logic             w_evt_valid;
    logic [1:0]       w_evt_type;
    logic [CNT_W-1:0] w_evt_clicks;
    logic             r_evt_valid;
    logic [1:0]       r_evt_type;
    logic [CNT_W-1:0] r_evt_clicks;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk       (clk),
      .btn_reset (btn_reset),
      .i_raw     (bus.btn_raw[ch]),
      .o_level   (w_level)
    );

    assign w_timer_inc  = (r_timer == TMR_MAX) ? r_timer : r_timer + 1'b1;
    assign w_clicks_inc = (r_clicks >= CNT_W'(MAX_CLICKS)) ? CNT_W'(MAX_CLICKS)
                                                           : r_clicks + 1'b1;
    assign w_max_hit  = (r_state == PRESSED) && !w_level && (w_clicks_inc == CNT_W'(MAX_CLICKS));
    assign w_long_hit = (r_state == PRESSED) && w_level && (r_timer == TMR_W'(LONG_CYC - 1));
    assign w_gap_hit  = (r_state == GAP) && !w_level && (r_timer == TMR_W'(GAP_CYC - 1));
`ifdef GESTURE_REPEAT_EN
    assign w_rep_hit  = (r_state == HELD) && w_level && (r_timer == TMR_W'(REPEAT_CYC - 1));
`else
    assign w_rep_hit  = 1'b0;
`endif

    // State, timer, click count and registered event outputs
    always_ff @(posedge clk or posedge btn_reset) begin
      if (btn_reset) begin
        r_state      <= IDLE;
        r_timer      <= '0;
        r_clicks     <= '0;
        r_evt_valid  <= 1'b0;
        r_evt_type   <= '0;
        r_evt_clicks <= '0;
      end else begin
        r_state      <= w_state_nxt;
        r_timer      <= w_timer_nxt;
        r_clicks     <= w_clicks_nxt;
        r_evt_valid  <= w_evt_valid;
        r_evt_type   <= w_evt_type;
        r_evt_clicks <= w_evt_clicks;
      end
    end

    // Next state, timer and click count; release takes priority over long-press
    always_comb begin
      w_state_nxt  = r_state;
      w_timer_nxt  = r_timer;
      w_clicks_nxt = r_clicks;
      case (r_state)
        IDLE: begin
          w_clicks_nxt = '0;
          if (w_level) begin
            w_state_nxt = PRESSED;
            w_timer_nxt = '0;
          end
        end
        PRESSED: begin
          w_timer_nxt = w_timer_inc;
          if (!w_level) begin
            if (w_max_hit) begin
              w_state_nxt  = IDLE;
              w_clicks_nxt = '0;
            end else begin
              w_state_nxt  = GAP;
              w_timer_nxt  = '0;
              w_clicks_nxt = w_clicks_inc;
            end
          end else if (w_long_hit) begin
            w_state_nxt = HELD;
            w_timer_nxt = '0;
          end
        end
        GAP: begin
          w_timer_nxt = w_timer_inc;
          if (w_level) begin
            w_state_nxt = PRESSED;
            w_timer_nxt = '0;
          end else if (w_gap_hit) begin
            w_state_nxt  = IDLE;
            w_clicks_nxt = '0;
          end
        end
        HELD: begin
          if (!w_level) begin
            w_state_nxt  = IDLE;
            w_clicks_nxt = '0;
          end
`ifdef GESTURE_REPEAT_EN
          else begin
            w_timer_nxt = w_rep_hit ? '0 : w_timer_inc;
          end
`endif
        end
        default: begin
          w_state_nxt  = IDLE;
          w_clicks_nxt = '0;
        end
      endcase
    end

    // Event decode for the deciding FSM cycle; fields are zero when no event
    always_comb begin
      w_evt_valid  = 1'b0;
      w_evt_type   = EVT_CLICK;
      w_evt_clicks = '0;
      if (w_max_hit) begin
        w_evt_valid  = 1'b1;
        w_evt_type   = EVT_CLICK;
        w_evt_clicks = w_clicks_inc;
      end else if (w_long_hit) begin
        w_evt_valid  = 1'b1;
        w_evt_type   = EVT_LONG;
        w_evt_clicks = r_clicks;
      end else if (w_gap_hit) begin
        w_evt_valid  = 1'b1;
        w_evt_type   = EVT_CLICK;
        w_evt_clicks = r_clicks;
      end else if (w_rep_hit) begin
        w_evt_valid  = 1'b1;
        w_evt_type   = EVT_REPEAT;
        w_evt_clicks = r_clicks;
      end
    end

    assign w_level_all[ch]                   = w_level;
    assign w_valid_all[ch]                   = r_evt_valid;
    assign w_type_all[2*ch +: 2]             = r_evt_type;
    assign w_clicks_all[CNT_W*ch +: CNT_W]   = r_evt_clicks;
  end

  assign bus.btn_level  = w_level_all;
  assign bus.evt_valid  = w_valid_all;
  assign bus.evt_type   = w_type_all;
  assign bus.evt_clicks = w_clicks_all;

endmodule

// File: doc/btn_gesture_decoder.md
Name: btn_gesture_decoder

Overview:
- Multi-channel push-button gesture classifier for the Basys3 timer family.
- Per channel: synchronise and debounce a raw button, then classify the press pattern as multi-click (1..MAX_CLICKS), long press, or held-repeat.
- Emits one-cycle event pulses to the mode/set control logic.
- Generalises the single-button short/long/double/triple/four-click decoding to N_CH channels with parametrised timing.

Parameters:
- N_CH, 1, number of independent button channels.
- DEB_CYC, 2, consecutive stable synchronised samples required to change the debounced level (>=1).
- LONG_CYC, 10, debounced-high cycles that classify a press as long.
- GAP_CYC, 15, debounced-low cycles after a release that close a click sequence.
- REPEAT_CYC, 20, period of REPEAT events while held after LONG.
- MAX_CLICKS, 4, click-count saturation; reaching it closes the sequence immediately.
- CNT_W, 3, width of the click-count field (must hold MAX_CLICKS).

Ports:
- clk  in  1  system clock.
- btn_reset  in  1  asynchronous active-high reset.
- btn_raw  in  N_CH  raw asynchronous button inputs.
- btn_level  out  N_CH  debounced level per channel.
- evt_valid  out  N_CH  one-cycle event strobe per channel.
- evt_type  out  2*N_CH  event type per channel: 0 CLICK, 1 LONG, 2 REPEAT, 3 reserved.
- evt_clicks  out  CNT_W*N_CH  click count attached to the event.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high on btn_reset, clock is clk. Asserting btn_reset at any time immediately clears all synchroniser, debounce, timer, count and FSM state. After reset: all outputs 0, every FSM in IDLE.
- Input path: 2-FF synchroniser per channel. Debounce counter loads the new level after DEB_CYC consecutive samples differing from btn_level. Both press and release edges are delayed by the same 2+DEB_CYC cycles, so pulse width is preserved. Glitches shorter than DEB_CYC samples are ignored.
- Per-channel FSM, timer (width from package) and click counter; channels are fully independent.
- IDLE: clicks=0. On btn_level rising -> PRESSED, timer=0.
- PRESSED: timer increments each cycle.
  - If btn_level is low: release wins. clicks = min(clicks+1, MAX_CLICKS).
    - If the new value equals MAX_CLICKS: emit CLICK(clicks), go to IDLE.
    - Otherwise: go to GAP, timer=0.
  - Else if timer==LONG_CYC-1: emit LONG with evt_clicks = clicks accumulated before this press (e.g. short+long gives 1), go to HELD, timer=0.
- GAP: timer increments.
  - btn_level rising -> PRESSED, timer=0.
  - Else if timer==GAP_CYC-1: emit CLICK(clicks), go to IDLE.
- HELD: on btn_level low -> IDLE with no event. Repeat behaviour is defined under Optional Feature.
- Event outputs: evt_valid high for exactly one cycle, registered (one cycle after the deciding FSM cycle). evt_type and evt_clicks are valid only while evt_valid is high and hold 0 otherwise. At most one event per channel per cycle.
- Timers saturate; they never wrap.

Optional Feature:
- Macro: GESTURE_REPEAT_EN.
- Defined: in HELD, timer increments; at timer==REPEAT_CYC-1 emit REPEAT (evt_clicks = the same value reported with LONG), timer=0. Repeats until release.
- Undefined: HELD only waits for release; REPEAT is never produced and the HELD timer logic is removed.

Decomposition:
- Package btn_gesture_pkg:
  - event-type constants EVT_CLICK/EVT_LONG/EVT_REPEAT;
  - FSM state encoding IDLE/PRESSED/GAP/HELD;
  - timer-width function clog2(max(LONG_CYC, GAP_CYC, REPEAT_CYC)).
- Sub-module btn_debounce (synchroniser + debounce, one per channel, parameter DEB_CYC).
- FSM generated per channel inside the top block.

Test Plan:
- Reset held 102 ns, then a single 50 ns press (10 ns clk) -> exactly one CLICK, clicks=1, about 15 cycles after debounced release; nothing else.
- Three 50 ns presses separated by 50 ns gaps -> one CLICK, clicks=3. Four such presses -> CLICK, clicks=4, emitted on the 4th release without waiting GAP_CYC.
- 110 ns press -> LONG, clicks=0; release produces no further event. Short press then 110 ns press with a 50 ns gap -> single LONG, clicks=1.
- 500 ns press with GESTURE_REPEAT_EN -> LONG at debounced cycle 10, then REPEAT at +20 and +40 cycles (2 REPEATs). Without the macro -> LONG only.
- 1-cycle glitches on btn_raw and btn_reset pulsed mid-GAP -> no event from the glitch; outputs zero immediately on reset; the next press decodes normally.
- N_CH=2: channel 0 double-click concurrent with channel 1 long press -> independent CLICK(2) on ch0 and LONG(0) on ch1, no cross-talk.
